io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_arbiter_pkg.sv | 16 +
 rtl/io_bus_arbiter_if.sv | 45 ++++
 rtl/io_bus_arbiter_rr_arb2.sv | 20 ++
 rtl/io_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Read data returned with every error acknowledge.
    localparam logic [7:0] ERR_DATA = 8'hFF;

    // Default cap on cycles spent waiting for a peripheral ready.
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bundles both master request/ack channels and the shared peripheral bus.
interface io_bus_arbiter_if
    import io_bus_pkg::*;
#(
    parameter int NUM_DEV    = 4,
    parameter int SEL_W      = 2,
    parameter int DEV_ADDR_W = 4
);
    localparam int AW = SEL_W + DEV_ADDR_W;

    logic                  m0_req, m0_we, m0_ack, m0_err;
    logic [AW-1:0]         m0_addr;
    logic [7:0]            m0_wdata, m0_rdata;

    logic                  m1_req, m1_we, m1_ack, m1_err;
    logic [AW-1:0]         m1_addr;
    logic [7:0]            m1_wdata, m1_rdata;

    logic [NUM_DEV-1:0]    dev_read, dev_write;
    logic [DEV_ADDR_W-1:0] dev_addr;
    logic [7:0]            dev_wdata;
    logic [NUM_DEV-1:0]    dev_ready_r, dev_ready_w;
    logic [NUM_DEV*8-1:0]  dev_rdata;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output dev_read, dev_write, dev_addr, dev_wdata,
        input  dev_ready_r, dev_ready_w, dev_rdata
    );

    // Environment side: masters and peripherals.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  dev_read, dev_write, dev_addr, dev_wdata,
        output dev_ready_r, dev_ready_w, dev_rdata
    );

endinterface

// File: rtl/io_bus_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; purely combinational.
module rr_arb2
    import io_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       update,
    input  logic       rr_last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        gnt_idx = (&req) ? ~rr_last : req[1];
        gnt     = '0;
        if (update && (|req))
            gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Sequences register accesses from two masters onto level-strobe peripherals.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int NUM_DEV    = 4,
    parameter int SEL_W      = 2,
    parameter int DEV_ADDR_W = 4,
    parameter int TIMEOUT    = DEF_TIMEOUT
)(
    input logic              clk,
    input logic              reset,
    io_bus_arbiter_if.slave  bus
);

    localparam int AW = SEL_W + DEV_ADDR_W;

    state_t                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic                  cur_q, cur_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_DEV-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [DEV_ADDR_W-1:0] daddr_q, daddr_d;
    logic [7:0]            dwdata_q, dwdata_d;
    logic [1:0]            ack_q, ack_d, err_q, err_d;
    logic [1:0][7:0]       rdata_q, rdata_d;

    logic [1:0]            req, gnt;
    logic                  gnt_idx;
    logic                  g_we, g_bad, ready_hit;
    logic [AW-1:0]         g_addr;
    logic [7:0]            g_wdata, rd_mux;
    logic [SEL_W-1:0]      g_sel;
    logic [NUM_DEV-1:0]    g_oh, cur_oh;

    assign req = {bus.m1_req, bus.m0_req};

    rr_arb2 u_arb (
        .req     (req),
        .update  (state_q == IDLE),
        .rr_last (rr_last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign g_we    = gnt_idx ? bus.m1_we    : bus.m0_we;
    assign g_addr  = gnt_idx ? bus.m1_addr  : bus.m0_addr;
    assign g_wdata = gnt_idx ? bus.m1_wdata : bus.m0_wdata;
    assign g_sel   = g_addr[AW-1 -: SEL_W];
    assign g_bad   = (32'(g_sel) >= NUM_DEV);

    // Device decode for the new grant and the access in flight, plus read-data mux.
    always_comb begin
        g_oh   = '0;
        cur_oh = '0;
        rd_mux = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            g_oh[i]   = (32'(g_sel) == i);
            cur_oh[i] = (32'(sel_q) == i);
            if (cur_oh[i])
                rd_mux = bus.dev_rdata[i*8 +: 8];
        end
    end

    // Only the selected device's ready in the access direction may complete it.
    assign ready_hit = |((we_q ? bus.dev_ready_w : bus.dev_ready_r) & cur_oh);

    // Next-state and next-output logic; every output is a register.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        cur_d     = cur_q;
        we_d      = we_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        ack_d     = '0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    cur_d = gnt_idx;
                    we_d  = g_we;
                    sel_d = g_sel;
                    // The pointer moves only when both masters contend.
                    if (&req)
                        rr_last_d = gnt_idx;
                    if (g_bad) begin
                        state_d          = RESP;
                        ack_d[gnt_idx]   = 1'b1;
                        err_d[gnt_idx]   = 1'b1;
                        rdata_d[gnt_idx] = ERR_DATA;
                    end else begin
                        daddr_d  = g_addr[DEV_ADDR_W-1:0];
                        dwdata_d = g_wdata;
                        rd_d     = g_we ? '0 : g_oh;
                        wr_d     = g_we ? g_oh : '0;
                        cnt_d    = '0;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // Ready takes priority over a timeout landing in the same cycle.
                if (ready_hit) begin
                    rd_d           = '0;
                    wr_d           = '0;
                    state_d        = RESP;
                    ack_d[cur_q]   = 1'b1;
                    err_d[cur_q]   = 1'b0;
                    rdata_d[cur_q] = we_q ? 8'h00 : rd_mux;
                end else if (cnt_d == 8'(TIMEOUT)) begin
                    rd_d           = '0;
                    wr_d           = '0;
                    state_d        = RESP;
                    ack_d[cur_q]   = 1'b1;
                    err_d[cur_q]   = 1'b1;
                    rdata_d[cur_q] = ERR_DATA;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            cur_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            cur_q     <= cur_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.m0_ack    = ack_q[0];
    assign bus.m0_err    = err_q[0];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.m1_err    = err_q[1];
    assign bus.m1_rdata  = rdata_q[1];
    assign bus.dev_read  = rd_q;
    assign bus.dev_write = wr_q;
    assign bus.dev_addr  = daddr_q;
    assign bus.dev_wdata = dwdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench: master drivers push expectations, a monitor pops on every ack.
module tb_io_bus_arbiter;

    localparam int ND = 3;
    localparam int SW = 2;
    localparam int LW = 4;
    localparam int TO = 8;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    io_bus_arbiter_if #(.NUM_DEV(ND), .SEL_W(SW), .DEV_ADDR_W(LW)) bus ();

    io_bus_arbiter #(.NUM_DEV(ND), .SEL_W(SW), .DEV_ADDR_W(LW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Peripheral models: registered ready after dly strobe cycles, optional noise.
    logic [7:0]    mem [ND][16];
    logic [ND-1:0] rdy_r = '0, rdy_w = '0;
    int            scnt [ND];
    int            dly  [ND];
    bit            dead [ND];
    bit            noise_all = 0;
    int            noise_pct = 0;

    // Reference storage, updated when a request is issued.
    logic [7:0]    ref_mem [ND][16];
    exp_t          q0[$], q1[$];
    int            ack_order[$];
    exp_t          me0, me1;

    function automatic logic [7:0] init_val(int i, int a);
        if (i == 1 && a == 2) return 8'hA5;
        return 8'(i * 37 + a * 11 + 90);
    endfunction

    function automatic bit nz();
        return noise_all || ($urandom_range(99) < noise_pct);
    endfunction

    function automatic bit other_active(int i);
        logic [ND-1:0] mask;
        mask = ND'(1) << i;
        return ((bus.dev_read | bus.dev_write) & ~mask) != '0;
    endfunction

    assign bus.dev_ready_r = rdy_r;
    assign bus.dev_ready_w = rdy_w;

    always_comb begin
        bus.dev_rdata = '0;
        for (int i = 0; i < ND; i++)
            bus.dev_rdata[i*8 +: 8] = mem[i][bus.dev_addr];
    end

    always @(posedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (reset) begin
                scnt[i]  <= 0;
                rdy_r[i] <= 1'b0;
                rdy_w[i] <= 1'b0;
                for (int a = 0; a < 16; a++) mem[i][a] <= init_val(i, a);
            end else begin
                scnt[i]  <= (bus.dev_read[i] | bus.dev_write[i]) ? scnt[i] + 1 : 0;
                rdy_r[i] <= bus.dev_read[i] ? (!dead[i] && scnt[i] >= dly[i])
                                            : (nz() && (bus.dev_write[i] || other_active(i)));
                rdy_w[i] <= bus.dev_write[i] ? (!dead[i] && scnt[i] >= dly[i])
                                             : (nz() && (bus.dev_read[i] || other_active(i)));
                if (bus.dev_write[i]) mem[i][bus.dev_addr] <= bus.dev_wdata;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    task automatic init_ref();
        for (int i = 0; i < ND; i++)
            for (int a = 0; a < 16; a++) ref_mem[i][a] = init_val(i, a);
    endtask

    // Spec-level outcome of one request.
    task automatic predict(input logic we, input logic [5:0] addr, input logic [7:0] wd, output exp_t e);
        int s, la;
        s  = int'(addr[5:4]);
        la = int'(addr[3:0]);
        if (s >= ND || dead[s]) begin
            e.err = 1'b1; e.rdata = 8'hFF;
        end else if (we) begin
            ref_mem[s][la] = wd;
            e.err = 1'b0; e.rdata = 8'h00;
        end else begin
            e.err = 1'b0; e.rdata = ref_mem[s][la];
        end
    endtask

    // Monitor: checks every ack against the owning master's queue.
    always @(negedge clk) begin
        if (!reset) begin
            chk("strobe_onehot", 64'(($countones({bus.dev_read, bus.dev_write}) <= 1) &&
                                     ((bus.dev_read & bus.dev_write) == '0)), 64'd1);
            if (bus.m0_ack && bus.m1_ack) fail_now("dual_ack");
            if (bus.m0_ack) begin
                if (q0.size() == 0) fail_now("m0_spurious_ack");
                else begin
                    me0 = q0.pop_front();
                    chk("m0_err", 64'(bus.m0_err), 64'(me0.err));
                    chk("m0_rdata", 64'(bus.m0_rdata), 64'(me0.rdata));
                    ack_order.push_back(0);
                end
            end
            if (bus.m1_ack) begin
                if (q1.size() == 0) fail_now("m1_spurious_ack");
                else begin
                    me1 = q1.pop_front();
                    chk("m1_err", 64'(bus.m1_err), 64'(me1.err));
                    chk("m1_rdata", 64'(bus.m1_rdata), 64'(me1.rdata));
                    ack_order.push_back(1);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int m, input logic r, input logic we,
                           input logic [5:0] addr, input logic [7:0] wd);
        if (m == 0) begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
        end else begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
        end
    endtask

    // Issue one request (called just after a posedge); lat counts cycles to ack.
    task automatic issue(input int m, input logic we, input logic [5:0] addr, input logic [7:0] wd,
                         output int lat, output int nstb, output logic [2*ND-1:0] stb_or,
                         output logic [LW-1:0] last_addr);
        exp_t e;
        bit   got;
        predict(we, addr, wd, e);
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        set_req(m, 1'b1, we, addr, wd);
        lat = -1; nstb = 0; stb_or = '0; last_addr = '0; got = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if ((m == 0) ? bus.m0_ack : bus.m1_ack) begin
                got = 1; lat = k;
                break;
            end
            if (|{bus.dev_read, bus.dev_write}) begin
                nstb++;
                stb_or    = stb_or | {bus.dev_write, bus.dev_read};
                last_addr = bus.dev_addr;
            end
        end
        if (!got) fail_now($sformatf("m%0d_ack_timeout", m));
        sync();
        set_req(m, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic stream_reads(input int m, input int n);
        int lat, nstb;
        logic [2*ND-1:0] so;
        logic [LW-1:0] la;
        for (int k = 0; k < n; k++)
            issue(m, 1'b0, {2'($urandom_range(ND - 1)), 3'($urandom), 1'(m)}, 8'h00, lat, nstb, so, la);
    endtask

    task automatic rand_master(input int m, input int n);
        int lat, nstb;
        logic [2*ND-1:0] so;
        logic [LW-1:0] la;
        for (int k = 0; k < n; k++) begin
            issue(m, 1'($urandom), {2'($urandom_range(3)), 3'($urandom), 1'(m)}, 8'($urandom),
                  lat, nstb, so, la);
            repeat ($urandom_range(2)) sync();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.m0_rdata,
                                  bus.m1_rdata, bus.dev_read, bus.dev_write, bus.dev_addr,
                                  bus.dev_wdata}), 64'd0);
        sync();
        reset = 1'b0;
        init_ref();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nstb;
        logic [2*ND-1:0] so;
        logic [LW-1:0] la;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < ND; i++) begin dly[i] = 0; dead[i] = 0; end
        do_reset();

        // Basic read: strobe on device 1 for two cycles, ack in cycle 3.
        issue(0, 1'b0, 6'h12, 8'h00, lat, nstb, so, la);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_strobe_cycles", 64'(nstb), 64'd2);
        chk("rd_strobe_dev", 64'(so), 64'b000_010);
        chk("rd_dev_addr", 64'(la), 64'd2);

        // Bad select: no strobe, ack in cycle 1 with error.
        issue(1, 1'b1, 6'h30, 8'h5C, lat, nstb, so, la);
        chk("badsel_latency", 64'(lat), 64'd1);
        chk("badsel_strobes", 64'(nstb), 64'd0);

        // Continuous contention from reset alternates grants starting with m0.
        do_reset();
        ack_order.delete();
        fork
            stream_reads(0, 4);
            stream_reads(1, 4);
        join
        chk("alt_count", 64'(ack_order.size()), 64'd8);
        foreach (ack_order[i]) chk($sformatf("alt_order_%0d", i), 64'(ack_order[i]), 64'(i % 2));

        // Dead device times out after TO strobe cycles; then recovers.
        dead[0] = 1;
        issue(0, 1'b0, 6'h05, 8'h00, lat, nstb, so, la);
        chk("to_latency", 64'(lat), 64'(TO + 1));
        chk("to_strobe_cycles", 64'(nstb), 64'(TO));
        dead[0] = 0;
        issue(0, 1'b0, 6'h05, 8'h00, lat, nstb, so, la);
        chk("after_to_latency", 64'(lat), 64'd3);

        // Reset during the second ACCESS cycle aborts silently and restores the pointer.
        do_reset();
        dly[0] = 3;
        set_req(0, 1'b1, 1'b0, 6'h01, 8'h00);
        set_req(1, 1'b1, 1'b0, 6'h11, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_strobe", 64'(bus.dev_read), 64'b001);
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        init_ref();
        @(negedge clk);
        chk("post_reset_strobes", 64'({bus.dev_read, bus.dev_write}), 64'd0);
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_no_ack", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
        end
        dly[0] = 0;
        sync();
        ack_order.delete();
        fork
            stream_reads(1, 1);
            stream_reads(0, 1);
        join
        chk("post_reset_first", 64'(ack_order[0]), 64'd0);
        chk("post_reset_second", 64'(ack_order[1]), 64'd1);

        // Wrong-direction and foreign ready are ignored during a write to device 2.
        noise_all = 1;
        dly[2] = 3;
        issue(0, 1'b1, 6'h24, 8'h77, lat, nstb, so, la);
        chk("noise_latency", 64'(lat), 64'd6);
        chk("noise_strobe_cycles", 64'(nstb), 64'd5);
        noise_all = 0;
        dly[2] = 0;
        issue(0, 1'b0, 6'h24, 8'h00, lat, nstb, so, la);

        // Random traffic from both masters with noisy, variable-latency devices.
        noise_pct = 40;
        for (int i = 0; i < ND; i++) dly[i] = $urandom_range(3);
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
        repeat (3) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
